mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the MIPS datapath. Sits directly
//  downstream of the register file: consumes the two read-port values (rs, rt) and executes
//  MULT/MULTU/DIV/DIVU over multiple cycles, plus MTHI/MTLO.
//  Exposes HI/LO to the writeback mux for MFHI/MFLO and a busy flag for the stall logic.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  CLK      in   1      clock, all state updates on rising edge
//  RST_N    in   1      asynchronous active-low reset
//  start    in   1      request; sampled only when busy=0
//  op       in   3      mdu_op_t: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO
//  srca     in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO data)
//  srcb     in   WIDTH  rt value (multiplier / divisor)
//  flush    in   1      abort the in-flight operation (exception/branch squash)
//  busy     out  1      operation in flight; stall MFHI/MFLO and any new mdu op
//  done     out  1      one-cycle pulse; HI/LO updated in this same cycle
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
//  FSM states: IDLE -> MUL or DIV -> FIX -> IDLE.
//  IDLE, start=1, op=MULT/MULTU/DIV/DIVU (cycle 0):
//   - latch |srca|, |srcb| for signed ops, raw values for unsigned ops
//   - record result signs: product/quotient neg = sign(a)^sign(b); remainder neg = sign(a)
//   - go to MUL/DIV; busy=1 from cycle 1
//  MUL: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator, WIDTH cycles (1..32).
//  DIV: restoring, one quotient bit per cycle, WIDTH cycles (1..32).
//  FIX (cycle 33): apply two's-complement negation per recorded signs. At the end of cycle 33:
//   hi/lo written, done=1 for that cycle only, busy=0, state=IDLE.
//   Latency: start accepted at edge N -> done high in cycle N+33; a new start is accepted the
//   same cycle done is high.
//  Results: MULT/MULTU {hi,lo} = full 2*WIDTH product. DIV/DIVU lo=quotient, hi=remainder
//   (remainder takes dividend sign). INT_MIN/-1: lo=0x80000000, hi=0 (no trap).
//  Divide by zero, any signedness: hi=srca as presented, lo=all ones; full latency, no trap.
//  MTHI/MTLO in IDLE: hi (resp. lo) <= srca at the next edge; no busy, no done.
//  start while busy=1: ignored entirely; hi/lo untouched. Upstream must stall on busy.
//  flush=1 while busy: return to IDLE next edge, busy=0, no done; hi/lo keep pre-op values.
//   flush in IDLE: no effect. flush and start in the same IDLE cycle: start dropped.
//  hi/lo change only on: FIX completion, MTHI/MTLO, reset. They are never partially updated.
//  Arithmetic is modulo 2^WIDTH per register. Counter width = $clog2(WIDTH)+1.
// STRUCTURE
//  Package mdu_pkg: mdu_op_t enum (3 bits), mdu_state_t enum {IDLE, MUL, DIV, FIX}.
//  Single module; the datapath shares one WIDTH+1 adder/subtractor between MUL and DIV.
//  No sub-module is required.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
//  2. MULT -7*3 -> {hi,lo}=0xFFFFFFFF_FFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  3. DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
//     DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, busy for 33 cycles.
//  5. MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, done never high.
//     A second start during busy -> ignored, result of the first op only.
//  6. Flush at cycle 10 of DIV -> busy=0 next cycle, no done, hi/lo keep prior values.
//     RST_N low mid-MUL -> immediate IDLE, hi=lo=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
package mdu_pkg;

  // Operation codes presented by the decode stage.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  // Sequencer states: one iteration phase per operation class, then a sign fix-up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Signed operations run on magnitudes; result signs are restored in the FIX cycle.
// One WIDTH+1 adder is shared: shift-add for MUL, trial subtraction for DIV.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               neg_pq_q, neg_pq_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  mdu_op_t            op_s;
  logic               signed_op_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [WIDTH:0]     add_a_s, add_b_s;
  logic               add_cin_s;
  logic [WIDTH+1:0]   sum_s;
  logic [2*WIDTH-1:0] mul_step_s, div_step_s;
  logic [WIDTH-1:0]   new_rem_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

  assign op_s        = mdu_op_t'(op);
  assign signed_op_s = (op_s == MDU_MULT) || (op_s == MDU_DIV);
  assign a_neg_s     = signed_op_s & srca[WIDTH-1];
  assign b_neg_s     = signed_op_s & srcb[WIDTH-1];
  assign abs_a_s     = a_neg_s ? ({WIDTH{1'b0}} - srca) : srca;
  assign abs_b_s     = b_neg_s ? ({WIDTH{1'b0}} - srcb) : srcb;

  // Shared adder operands: add multiplicand in MUL, subtract divisor (a + ~b + 1) in DIV.
  always_comb begin
    if (state_q == DIV) begin
      add_a_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_b_s   = ~{1'b0, opb_q};
      add_cin_s = 1'b1;
    end else begin
      add_a_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b_s   = {1'b0, opb_q};
      add_cin_s = 1'b0;
    end
  end

  assign sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(WIDTH+1){1'b0}}, add_cin_s};

  // One iteration of each algorithm; for DIV the adder carry-out means "no borrow".
  always_comb begin
    if (acc_q[0]) begin
      mul_step_s = {sum_s[WIDTH:0], acc_q[WIDTH-1:1]};
    end else begin
      mul_step_s = {1'b0, acc_q[2*WIDTH-1:1]};
    end
    if (sum_s[WIDTH+1]) begin
      new_rem_s = sum_s[WIDTH-1:0];
    end else begin
      new_rem_s = add_a_s[WIDTH-1:0];
    end
    div_step_s = {new_rem_s, acc_q[WIDTH-2:0], sum_s[WIDTH+1]};
  end

  // Sign restoration and divide-by-zero substitution applied in the FIX cycle.
  always_comb begin
    prod_s = neg_pq_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
    if (is_div_q) begin
      if (div0_q) begin
        fix_hi_s = raw_a_q;
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        fix_hi_s = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH])
                             : acc_q[2*WIDTH-1:WIDTH];
        fix_lo_s = neg_pq_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      end
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Sequencer: accept requests in IDLE, iterate WIDTH times, commit HI/LO in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    raw_a_d   = raw_a_q;
    neg_pq_d  = neg_pq_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op_s)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              is_div_d  = (op_s == MDU_DIV) || (op_s == MDU_DIVU);
              state_d   = is_div_d ? DIV : MUL;
              cnt_d     = {CW{1'b0}};
              acc_d     = {{WIDTH{1'b0}}, abs_a_s};
              opb_d     = abs_b_s;
              raw_a_d   = srca;
              neg_pq_d  = a_neg_s ^ b_neg_s;
              neg_rem_d = a_neg_s;
              div0_d    = (srcb == {WIDTH{1'b0}});
            end
            MDU_MTHI: hi_d = srca;
            MDU_MTLO: lo_d = srca;
            default:  state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = (state_q == DIV) ? div_step_s : mul_step_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_ITER) begin
            state_d = FIX;
          end else begin
            state_d = state_q;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          hi_d   = fix_hi_s;
          lo_d   = fix_lo_s;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and architectural registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      opb_q     <= {WIDTH{1'b0}};
      raw_a_q   <= {WIDTH{1'b0}};
      neg_pq_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      raw_a_q   <= raw_a_d;
      neg_pq_q  <= neg_pq_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
